axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Single-port AXI3 responder (slave) backed by an internal word-addressed RAM.
- Sits at the far end of the CPU's AXI master bridge as a simulation and FPGA memory target.
- Serves one outstanding read and one outstanding write concurrently, with programmable per-transaction response delays so the CPU's stall paths can be exercised.
- Accepts single-beat, 4-byte transfers only; anything else gets SLVERR.

Parameters:
- ADDR_W, 16, word-index width; RAM depth is 2^ADDR_W words of 32 bits.
- RD_DELAY, 2, idle cycles between AR handshake and first rvalid (0..15).
- WR_DELAY, 1, idle cycles between write commit eligibility and bvalid (0..15).

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous, active-high reset
- arid  in  4  read ID
- araddr  in  32  read byte address
- arlen  in  8  burst length-1
- arsize  in  3  transfer size
- arburst/arlock/arcache/arprot  in  2/2/4/3  ignored
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  4  echoed arid
- rdata  out  32  read data
- rresp  out  2  OKAY=00, SLVERR=10
- rlast  out  1  last beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- awid  in  4  write ID
- awaddr  in  32  write byte address
- awlen  in  8  burst length-1
- awsize  in  3  transfer size
- awburst/awlock/awcache/awprot  in  2/2/4/3  ignored
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wid  in  4  ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  ignored
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  4  echoed awid
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready

Behaviour:
- Clocking and reset: clock aclk; reset reset, synchronous, active-high.
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rlast=0, rid=0, bid=0, rresp=0, bresp=0, rdata=0, both FSMs in IDLE, delay counters 0.
- Reset does not clear the RAM. Reset mid-transaction drops all latched requests silently.
- Word index = addr[ADDR_W+1:2]. Upper bits alias; addr[1:0] are ignored.
- A request is legal only if len==0 and size==3'b010. Otherwise resp=SLVERR, rdata=0, and the RAM is not written.
- Read FSM, R_IDLE:
  - arready=1.
  - On arvalid&arready, latch arid, index and legality; arready goes 0.
  - Next state is R_DELAY with cnt=RD_DELAY, or R_RESP directly if RD_DELAY==0.
- Read FSM, R_DELAY: cnt decrements each cycle; at cnt==1, move to R_RESP.
- Read FSM, R_RESP entry:
  - rdata is registered from RAM at the entry edge.
  - rvalid=1, rlast=1; rid and rresp are driven.
  - All R outputs stay stable while rvalid&!rready.
- Read FSM, leaving R_RESP: on rvalid&rready, rvalid=0, arready=1, return to R_IDLE. A new AR can be accepted no earlier than the cycle after the R handshake.
- Read latency: AR handshake at edge T gives rvalid high from edge T+1+RD_DELAY.
- Write FSM, W_IDLE:
  - awready and wready operate independently. Each drops after its own handshake and the payload is latched (awid, index and legality; wdata and wstrb).
  - AW and W may arrive in either order or in the same cycle.
  - When both are latched, go to W_DELAY (cnt=WR_DELAY), or W_RESP if WR_DELAY==0.
- Write FSM, W_RESP entry:
  - Commit RAM[index] bytes where wstrb[i]=1, if legal.
  - bvalid=1; bid and bresp are driven and held until bready.
- Write FSM, leaving W_RESP: on the B handshake, awready=1, wready=1, return to W_IDLE.
- Write latency: the later of the AW/W handshakes at edge T gives bvalid from edge T+1+WR_DELAY.
- Read/write collision: if a write commits on the same edge that read rdata is captured for the same index, the read returns the old data. A read captured on any later edge sees the new data.
- Read and write FSMs are fully independent; no channel ever blocks the other.

Test Plan:
1. After reset, sample outputs without stimulus -> arready=awready=wready=1, rvalid=bvalid=0 for 10 cycles.
2. AW addr=0x100, id=3 and W data=0xDEADBEEF, strb=4'hF in the same cycle, RD_DELAY=2, WR_DELAY=1:
   - bvalid rises 2 edges later with bid=3, bresp=00.
   - Then AR 0x100, id=5 -> rvalid 3 edges after the AR handshake, rdata=0xDEADBEEF, rid=5, rlast=1, rresp=00.
3. W sent 4 cycles before AW, strb=4'b0101, data=0x11223344 over 0xDEADBEEF -> no bvalid until AW arrives; readback returns 0xDE22BE44.
4. rready held low for 5 cycles after rvalid -> rvalid, rdata and rid stay stable, and arready stays 0 with arvalid pending. Likewise bvalid/bid stay stable with bready low.
5. AR with arlen=3 and AW with awsize=1 -> rresp=10, rdata=0, bresp=10; a subsequent read confirms the target word is unchanged.
6. Assert reset while in R_DELAY and W_DELAY -> next cycle arready=awready=wready=1, rvalid=bvalid=0; previously written RAM data is still readable.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3 single-beat SRAM responder.
// One read and one write can be in flight at the same time, each with a fixed
// response delay. Only 4-byte, single-beat transfers are legal; anything else
// completes with SLVERR and leaves the RAM untouched.
module axi_sram_slave #(
    parameter int ADDR_W   = 16,
    parameter int RD_DELAY = 2,
    parameter int WR_DELAY = 1
) (
    input  logic        aclk,
    input  logic        reset,
    // read address channel
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data channel
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address channel
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data channel
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response channel
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] RD_CNT      = 4'(RD_DELAY);
    localparam logic [3:0] WR_CNT      = 4'(WR_DELAY);

    // Word-addressed backing store; never cleared by reset.
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Fields that the protocol carries but this target does not need.
    logic unused_inputs;
    assign unused_inputs = ^{arburst, arlock, arcache, arprot,
                             awburst, awlock, awcache, awprot,
                             wid, wlast,
                             araddr[31:ADDR_W+2], araddr[1:0],
                             awaddr[31:ADDR_W+2], awaddr[1:0]};

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} rstate_t;

    rstate_t           rstate_reg, rstate_next;
    logic [3:0]        rcnt_reg, rcnt_next;
    logic [3:0]        rid_reg;
    logic [ADDR_W-1:0] ridx_reg;
    logic              rlegal_reg;
    logic [1:0]        rresp_reg;
    logic [31:0]       rdata_reg;

    logic              ar_hs;
    logic [ADDR_W-1:0] ar_idx;
    logic              ar_legal;
    logic              rd_capture;
    logic [ADDR_W-1:0] ridx_eff;
    logic              rlegal_eff;

    assign arready  = (rstate_reg == R_IDLE);
    assign ar_hs    = arvalid & arready;
    assign ar_idx   = araddr[ADDR_W+1:2];
    assign ar_legal = (arlen == 8'd0) && (arsize == 3'b010);

    // With zero delay the RAM is read on the AR handshake edge itself, before
    // the request fields have been latched, so take them straight from the bus.
    assign ridx_eff   = (rstate_reg == R_IDLE) ? ar_idx   : ridx_reg;
    assign rlegal_eff = (rstate_reg == R_IDLE) ? ar_legal : rlegal_reg;
    assign rd_capture = (rstate_next == R_RESP) && (rstate_reg != R_RESP);

    // Read FSM next-state logic.
    always_comb begin
        rstate_next = rstate_reg;
        rcnt_next   = rcnt_reg;
        case (rstate_reg)
            R_IDLE: begin
                if (ar_hs) begin
                    if (RD_DELAY == 0) begin
                        rstate_next = R_RESP;
                    end else begin
                        rstate_next = R_DELAY;
                        rcnt_next   = RD_CNT;
                    end
                end
            end
            R_DELAY: begin
                if (rcnt_reg <= 4'd1) begin
                    rstate_next = R_RESP;
                    rcnt_next   = 4'd0;
                end else begin
                    rcnt_next = rcnt_reg - 4'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rstate_next = R_IDLE;
                end
            end
            default: begin
                rstate_next = R_IDLE;
                rcnt_next   = 4'd0;
            end
        endcase
    end

    // Read FSM state and latched AR request.
    always_ff @(posedge aclk) begin
        if (reset) begin
            rstate_reg <= R_IDLE;
            rcnt_reg   <= 4'd0;
            rid_reg    <= 4'd0;
            ridx_reg   <= '0;
            rlegal_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
        end else begin
            rstate_reg <= rstate_next;
            rcnt_reg   <= rcnt_next;
            if (ar_hs) begin
                rid_reg    <= arid;
                ridx_reg   <= ar_idx;
                rlegal_reg <= ar_legal;
                rresp_reg  <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Registered RAM read, taken once on entry to the response state and then
    // held for as long as the master stalls.
    always_ff @(posedge aclk) begin
        if (reset) begin
            rdata_reg <= 32'd0;
        end else if (rd_capture) begin
            rdata_reg <= rlegal_eff ? mem[ridx_eff] : 32'd0;
        end
    end

    assign rvalid = (rstate_reg == R_RESP);
    assign rlast  = rvalid;
    assign rid    = rid_reg;
    assign rresp  = rresp_reg;
    assign rdata  = rdata_reg;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DELAY, W_RESP} wstate_t;

    wstate_t           wstate_reg, wstate_next;
    logic [3:0]        wcnt_reg, wcnt_next;
    logic              aw_got_reg, w_got_reg;
    logic [3:0]        bid_reg;
    logic [ADDR_W-1:0] widx_reg;
    logic              wlegal_reg;
    logic [1:0]        bresp_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;

    logic              aw_hs, w_hs;
    logic [ADDR_W-1:0] aw_idx;
    logic              aw_legal;
    logic              wr_commit;
    logic [ADDR_W-1:0] widx_eff;
    logic              wlegal_eff;
    logic [31:0]       wdata_eff;
    logic [3:0]        wstrb_eff;
    logic [3:0]        wr_be;

    assign awready  = (wstate_reg == W_IDLE) && !aw_got_reg;
    assign wready   = (wstate_reg == W_IDLE) && !w_got_reg;
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign aw_idx   = awaddr[ADDR_W+1:2];
    assign aw_legal = (awlen == 8'd0) && (awsize == 3'b010);

    // Either half may still be on the bus when the commit happens with zero
    // delay, so prefer the latched copy only once it exists.
    assign widx_eff   = aw_got_reg ? widx_reg   : aw_idx;
    assign wlegal_eff = aw_got_reg ? wlegal_reg : aw_legal;
    assign wdata_eff  = w_got_reg  ? wdata_reg  : wdata;
    assign wstrb_eff  = w_got_reg  ? wstrb_reg  : wstrb;
    assign wr_commit  = (wstate_next == W_RESP) && (wstate_reg != W_RESP) && !reset;

    // Write FSM next-state logic.
    always_comb begin
        wstate_next = wstate_reg;
        wcnt_next   = wcnt_reg;
        case (wstate_reg)
            W_IDLE: begin
                if ((aw_got_reg || aw_hs) && (w_got_reg || w_hs)) begin
                    if (WR_DELAY == 0) begin
                        wstate_next = W_RESP;
                    end else begin
                        wstate_next = W_DELAY;
                        wcnt_next   = WR_CNT;
                    end
                end
            end
            W_DELAY: begin
                if (wcnt_reg <= 4'd1) begin
                    wstate_next = W_RESP;
                    wcnt_next   = 4'd0;
                end else begin
                    wcnt_next = wcnt_reg - 4'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_next = W_IDLE;
                end
            end
            default: begin
                wstate_next = W_IDLE;
                wcnt_next   = 4'd0;
            end
        endcase
    end

    // Write FSM state plus independently latched AW and W payloads.
    always_ff @(posedge aclk) begin
        if (reset) begin
            wstate_reg <= W_IDLE;
            wcnt_reg   <= 4'd0;
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
            bid_reg    <= 4'd0;
            widx_reg   <= '0;
            wlegal_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
            wdata_reg  <= 32'd0;
            wstrb_reg  <= 4'd0;
        end else begin
            wstate_reg <= wstate_next;
            wcnt_reg   <= wcnt_next;
            if ((wstate_reg == W_RESP) && bready) begin
                aw_got_reg <= 1'b0;
                w_got_reg  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_got_reg <= 1'b1;
                end
                if (w_hs) begin
                    w_got_reg <= 1'b1;
                end
            end
            if (aw_hs) begin
                bid_reg    <= awid;
                widx_reg   <= aw_idx;
                wlegal_reg <= aw_legal;
                bresp_reg  <= aw_legal ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_hs) begin
                wdata_reg <= wdata;
                wstrb_reg <= wstrb;
            end
        end
    end

    // Per-lane write enables for the commit edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign wr_be[gi] = wr_commit & wlegal_eff & wstrb_eff[gi];
        end
    endgenerate

    // Byte-masked RAM write; a read captured on this same edge sees old data.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[widx_eff][8*i +: 8] <= wdata_eff[8*i +: 8];
            end
        end
    end

    assign bvalid = (wstate_reg == W_RESP);
    assign bid    = bid_reg;
    assign bresp  = bresp_reg;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a vector table of single transactions
// plus hand-written sequences for ordering, back-pressure and reset.
module tb_axi_sram_slave;

    localparam int RD_DELAY = 2;
    localparam int WR_DELAY = 1;

    logic        aclk = 1'b0;
    logic        reset;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_W(16), .RD_DELAY(RD_DELAY), .WR_DELAY(WR_DELAY)) dut (
        .aclk(aclk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    task automatic idle_inputs();
        arid = 0; araddr = 0; arlen = 0; arsize = 3'b010; arburst = 2'b01;
        arlock = 0; arcache = 0; arprot = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'b010; awburst = 2'b01;
        awlock = 0; awcache = 0; awprot = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 1; wvalid = 0; bready = 0;
    endtask

    // W is raised first; AW follows w_lead cycles later (0 = same cycle).
    // Latency counts edges from raising AW to bvalid being visible.
    task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] exp_resp, input int w_lead, input int b_hold);
        int  cnt;
        int  lat;
        bit  aw_h, w_h;
        cnt = 0;
        lat = -1;
        @(negedge aclk);
        wdata = data; wstrb = strb; wvalid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k == w_lead) begin
                awaddr = addr; awid = id; awlen = len; awsize = size; awvalid = 1'b1;
                cnt = 0;
            end else if (k < w_lead && k > 0) begin
                chk("wready_low_after_w", {31'd0, wready}, 32'd0);
                chk("no_bvalid_before_aw", {31'd0, bvalid}, 32'd0);
            end
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            @(posedge aclk);
            cnt++;
            @(negedge aclk);
            if (aw_h) awvalid = 1'b0;
            if (w_h)  wvalid  = 1'b0;
            if (bvalid && k >= w_lead) begin
                lat = cnt;
                break;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (lat < 0) begin
            timeout("bvalid_timeout");
            return;
        end
        chk("b_latency", lat, 1 + WR_DELAY);
        chk("bid", {28'd0, bid}, {28'd0, id});
        chk("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        for (int h = 0; h < b_hold; h++) begin
            @(posedge aclk);
            @(negedge aclk);
            chk("bvalid_held", {31'd0, bvalid}, 32'd1);
            chk("bid_held", {28'd0, bid}, {28'd0, id});
            chk("awready_low_held", {31'd0, awready}, 32'd0);
        end
        bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
        chk("awready_back", {31'd0, awready}, 32'd1);
        chk("wready_back", {31'd0, wready}, 32'd1);
        $display("write addr=0x%08h id=%0d data=0x%08h strb=%b lead=%0d resp=%0d lat=%0d",
                 addr, id, data, strb, w_lead, bresp, lat);
    endtask

    // Single read; with r_hold>0 rready stays low that many cycles while a
    // second AR waits on the bus, which must not be accepted.
    task automatic do_read(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] exp_resp, input logic [31:0] exp_data,
                           input int r_hold);
        int cnt;
        int lat;
        bit ar_h;
        cnt = 0;
        lat = -1;
        @(negedge aclk);
        araddr = addr; arid = id; arlen = len; arsize = size; arvalid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            ar_h = arvalid && arready;
            @(posedge aclk);
            cnt++;
            @(negedge aclk);
            if (ar_h) arvalid = 1'b0;
            if (rvalid) begin
                lat = cnt;
                break;
            end
        end
        arvalid = 1'b0;
        if (lat < 0) begin
            timeout("rvalid_timeout");
            return;
        end
        chk("r_latency", lat, 1 + RD_DELAY);
        chk("rid", {28'd0, rid}, {28'd0, id});
        chk("rresp", {30'd0, rresp}, {30'd0, exp_resp});
        chk("rdata", rdata, exp_data);
        chk("rlast", {31'd0, rlast}, 32'd1);
        if (r_hold > 0) begin
            araddr = addr + 32'd4; arid = id + 4'd1; arlen = 0; arsize = 3'b010;
            arvalid = 1'b1;
        end
        for (int h = 0; h < r_hold; h++) begin
            @(posedge aclk);
            @(negedge aclk);
            chk("rvalid_held", {31'd0, rvalid}, 32'd1);
            chk("rdata_held", rdata, exp_data);
            chk("rid_held", {28'd0, rid}, {28'd0, id});
            chk("arready_low_held", {31'd0, arready}, 32'd0);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rready = 1'b0;
        chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
        chk("arready_back", {31'd0, arready}, 32'd1);
        $display("read  addr=0x%08h id=%0d len=%0d size=%0d resp=%0d data=0x%08h lat=%0d",
                 addr, id, len, size, rresp, rdata, lat);
    endtask

    initial begin
        // addr, id, len, size, data, strb, exp_resp, exp_data
        vecs[0] = '{1'b1, 32'h0000_0100, 4'd3, 8'd0, 3'd2, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0100, 4'd5, 8'd0, 3'd2, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0204, 4'd1, 8'd0, 3'd2, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0204, 4'd2, 8'd0, 3'd2, 32'h0000_00AA, 4'h1, 2'b00, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0204, 4'd7, 8'd0, 3'd2, 32'h0,         4'h0, 2'b00, 32'hCAFE_F0AA};
        vecs[5] = '{1'b0, 32'h0004_0207, 4'd8, 8'd0, 3'd2, 32'h0,         4'h0, 2'b00, 32'hCAFE_F0AA};
        vecs[6] = '{1'b0, 32'h0000_0100, 4'd9, 8'd3, 3'd2, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0100, 4'd4, 8'd0, 3'd1, 32'h0000_0000, 4'hF, 2'b10, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_0100, 4'd6, 8'd0, 3'd2, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        reset = 1'b0;

        // Quiet bus after reset.
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk);
            @(negedge aclk);
            chk("rst_arready", {31'd0, arready}, 32'd1);
            chk("rst_awready", {31'd0, awready}, 32'd1);
            chk("rst_wready",  {31'd0, wready},  32'd1);
            chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
            chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        end
        chk("rst_rid_bid", {24'd0, rid, bid}, 32'd0);
        chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);

        // Table of single transactions.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].size,
                         vecs[i].data, vecs[i].strb, vecs[i].exp_resp, 0, 0);
            else
                do_read(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].size,
                        vecs[i].exp_resp, vecs[i].exp_data, 0);
        end

        // W four cycles ahead of AW, partial strobes.
        do_write(32'h0000_0100, 4'd10, 8'd0, 3'd2, 32'h1122_3344, 4'b0101, 2'b00, 4, 0);
        do_read(32'h0000_0100, 4'd11, 8'd0, 3'd2, 2'b00, 32'hDE22_BE44, 0);

        // Back-pressure on R and B.
        do_read(32'h0000_0100, 4'd12, 8'd0, 3'd2, 2'b00, 32'hDE22_BE44, 5);
        do_write(32'h0000_0308, 4'd13, 8'd0, 3'd2, 32'h0BAD_F00D, 4'hF, 2'b00, 0, 5);
        do_read(32'h0000_0308, 4'd14, 8'd0, 3'd2, 2'b00, 32'h0BAD_F00D, 0);

        // Reset while both FSMs are in their delay states.
        @(negedge aclk);
        araddr = 32'h0000_0100; arid = 4'd9; arlen = 0; arsize = 3'b010; arvalid = 1'b1;
        awaddr = 32'h0000_0204; awid = 4'd9; awlen = 0; awsize = 3'b010; awvalid = 1'b1;
        wdata = 32'h5555_5555; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("mid_arready_low", {31'd0, arready}, 32'd0);
        chk("mid_awready_low", {31'd0, awready}, 32'd0);
        reset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mrst_ready", {29'd0, arready, awready, wready}, 32'd7);
            chk("mrst_valid", {30'd0, rvalid, bvalid}, 32'd0);
            @(posedge aclk);
            @(negedge aclk);
        end
        // Dropped write must not have reached the RAM; earlier data survives.
        do_read(32'h0000_0204, 4'd1, 8'd0, 3'd2, 2'b00, 32'hCAFE_F0AA, 0);
        do_read(32'h0000_0100, 4'd2, 8'd0, 3'd2, 2'b00, 32'hDE22_BE44, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Overall guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
